// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared stream field indices, goal FSM encoding and widths
package pong_pkg;

    localparam int STREAM_W = 26;

    localparam int ACT    = 25;
    localparam int VS     = 24;
    localparam int HS     = 23;
    localparam int X_HI   = 22;
    localparam int X_LO   = 13;
    localparam int Y_HI   = 12;
    localparam int Y_LO   = 3;
    localparam int RGB_HI = 2;
    localparam int RGB_LO = 0;

    typedef enum logic [1:0] {
        ARMED      = 2'd0,
        SCORED     = 2'd1,
        WAIT_CLEAR = 2'd2
    } goal_state_t;

endpackage

// File: rtl/goal_side.sv
// rtl/goal_side.sv - per-side hit counter, frame evaluation and one-frame score pulse
module goal_side
    import pong_pkg::*;
#(
    parameter logic [7:0] min_pix = 8'd4
) (
    input  logic px_clk,
    input  logic reset,
    input  logic en,
    input  logic hit_px,
    input  logic frame_end,
    output logic goal
);

    logic [7:0]  r_count;
    goal_state_t r_state;
    logic        r_goal;

    logic [7:0]  w_count_inc;
    logic        w_hit_frame;

    // Saturating count including this cycle's pixel, so a hit on the frame_end cycle still counts
    always_comb begin
        w_count_inc = (r_count != 8'hFF) ? (r_count + {7'd0, hit_px}) : r_count;
        w_hit_frame = (w_count_inc >= min_pix);
    end

    // Counter, FSM and registered output; the output is the registered "next state is SCORED"
    // so it rises the cycle after frame_end and stays high for exactly one frame
    always_ff @(posedge px_clk or negedge reset) begin
        if (!reset) begin
            r_count <= 8'd0;
            r_state <= ARMED;
            r_goal  <= 1'b0;
        end else if (!en) begin
            r_count <= 8'd0;
            r_state <= ARMED;
            r_goal  <= 1'b0;
        end else if (frame_end) begin
            r_count <= 8'd0;
            case (r_state)
                ARMED: begin
                    if (w_hit_frame) begin
                        r_state <= SCORED;
                        r_goal  <= 1'b1;
                    end else begin
                        r_goal  <= 1'b0;
                    end
                end
                SCORED: begin
                    r_state <= WAIT_CLEAR;
                    r_goal  <= 1'b0;
                end
                WAIT_CLEAR: begin
                    if (!w_hit_frame) begin
                        r_state <= ARMED;
                    end
                    r_goal <= 1'b0;
                end
                default: begin
                    r_state <= ARMED;
                    r_goal  <= 1'b0;
                end
            endcase
        end else begin
            r_count <= w_count_inc;
        end
    end

    assign goal = r_goal;

endmodule

// File: rtl/goal_detector.sv
// rtl/goal_detector.sv - stream pass-through with left/right goal strip ball detection
module goal_detector
    import pong_pkg::*;
#(
    parameter logic [2:0] ball_color = 3'b010,
    parameter logic [9:0] goal_w     = 10'd4,
    parameter logic [9:0] h_active   = 10'd640,
    parameter logic [7:0] min_pix    = 8'd4
) (
    input  logic                px_clk,
    input  logic                reset,
    input  logic                en,
    input  logic [STREAM_W-1:0] strRGB_i,
    output logic [STREAM_W-1:0] strRGB_o,
    output logic                goal_l,
    output logic                goal_r
);

    localparam logic [9:0] RIGHT_X = h_active - goal_w;

    logic [STREAM_W-1:0] r_stream;
    logic                r_vs_prev;

    logic [9:0] w_x;
    logic       w_ball;
    logic       w_hit_l;
    logic       w_hit_r;
    logic       w_frame_end;

    // Strip decode and vsync rising-edge strobe, all on the incoming pixel
    always_comb begin
        w_x         = strRGB_i[X_HI:X_LO];
        w_ball      = strRGB_i[ACT] && (strRGB_i[RGB_HI:RGB_LO] == ball_color);
        w_hit_l     = w_ball && (w_x < goal_w);
        w_hit_r     = w_ball && (w_x >= RIGHT_X);
        w_frame_end = strRGB_i[VS] && !r_vs_prev;
    end

    // One-cycle stream delay and previous vsync; independent of en
    always_ff @(posedge px_clk or negedge reset) begin
        if (!reset) begin
            r_stream  <= '0;
            r_vs_prev <= 1'b0;
        end else begin
            r_stream  <= strRGB_i;
            r_vs_prev <= strRGB_i[VS];
        end
    end

    assign strRGB_o = r_stream;

    goal_side #(.min_pix(min_pix)) u_side_l (
        .px_clk    (px_clk),
        .reset     (reset),
        .en        (en),
        .hit_px    (w_hit_l),
        .frame_end (w_frame_end),
        .goal      (goal_l)
    );

    goal_side #(.min_pix(min_pix)) u_side_r (
        .px_clk    (px_clk),
        .reset     (reset),
        .en        (en),
        .hit_px    (w_hit_r),
        .frame_end (w_frame_end),
        .goal      (goal_r)
    );

endmodule

// File: tb/tb_goal_detector.sv
// tb/tb_goal_detector.sv - scoreboard bench for goal_detector
module tb_goal_detector;

    logic        px_clk;
    logic        reset;
    logic        en;
    logic [25:0] strRGB_i;
    logic [25:0] strRGB_o;
    logic        goal_l;
    logic        goal_r;

    goal_detector dut (
        .px_clk   (px_clk),
        .reset    (reset),
        .en       (en),
        .strRGB_i (strRGB_i),
        .strRGB_o (strRGB_o),
        .goal_l   (goal_l),
        .goal_r   (goal_r)
    );

    initial px_clk = 1'b0;
    always #5 px_clk = ~px_clk;

    typedef struct {
        logic [25:0] stream;
        logic        gl;
        logic        gr;
    } exp_t;

    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state: 0 armed, 1 scored, 2 waiting for clear frame
    int   m_cnt_l, m_cnt_r, m_st_l, m_st_r;
    logic m_vs;
    int   rise_l, rise_r;
    logic prev_gl, prev_gr;

    task automatic chk(input string tag, input logic [25:0] obs, input logic [25:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic side_model(input int c_in, input int st_in, input bit hit, input bit fe,
                              output int c_out, output int st_out);
        int c;
        c = c_in + (hit ? 1 : 0);
        st_out = st_in;
        if (fe) begin
            if (st_in == 0 && c >= 4) st_out = 1;
            else if (st_in == 1)      st_out = 2;
            else if (st_in == 2 && c < 4) st_out = 0;
            c_out = 0;
        end else begin
            c_out = c;
        end
    endtask

    task automatic model_reset();
        m_cnt_l = 0; m_cnt_r = 0; m_st_l = 0; m_st_r = 0; m_vs = 1'b0;
        prev_gl = 1'b0; prev_gr = 1'b0;
    endtask

    task automatic step(input logic [25:0] s, input logic e);
        exp_t  ex;
        exp_t  got;
        logic [9:0] x;
        bit    ball, hl, hr, fe;
        strRGB_i = s;
        en       = e;
        x    = s[22:13];
        ball = s[25] && (s[2:0] == 3'b010);
        hl   = ball && (x < 10'd4);
        hr   = ball && (x >= 10'd636);
        fe   = s[24] && !m_vs;
        m_vs = s[24];
        if (!e) begin
            m_cnt_l = 0; m_cnt_r = 0; m_st_l = 0; m_st_r = 0;
        end else begin
            side_model(m_cnt_l, m_st_l, hl, fe, m_cnt_l, m_st_l);
            side_model(m_cnt_r, m_st_r, hr, fe, m_cnt_r, m_st_r);
        end
        ex.stream = s;
        ex.gl     = (m_st_l == 1);
        ex.gr     = (m_st_r == 1);
        sb_q.push_back(ex);
        @(posedge px_clk);
        #1;
        got = sb_q.pop_front();
        chk("stream", strRGB_o, got.stream);
        chk("goal_l", {25'd0, goal_l}, {25'd0, got.gl});
        chk("goal_r", {25'd0, goal_r}, {25'd0, got.gr});
        if (goal_l && !prev_gl) rise_l++;
        if (goal_r && !prev_gr) rise_r++;
        prev_gl = goal_l;
        prev_gr = goal_r;
    endtask

    task automatic frame(input int nl, input int xl, input int nr, input int xr, input logic e);
        int len;
        logic [25:0] s;
        len = (nl + nr + 10 > 24) ? (nl + nr + 10) : 24;
        for (int i = 0; i < len; i++) begin
            s = '0;
            s[24] = (i < 2);
            s[23] = (i % 8 == 7);
            s[12:3] = 10'(i);
            if (i >= 4 && i < 4 + nl) begin
                s[25] = 1'b1; s[22:13] = 10'(xl); s[2:0] = 3'b010;
            end else if (i >= 4 + nl && i < 4 + nl + nr) begin
                s[25] = 1'b1; s[22:13] = 10'(xr); s[2:0] = 3'b010;
            end else if (i >= 4) begin
                s[25] = 1'b1;
                s[22:13] = 10'($urandom_range(4, 635));
                s[2:0] = 3'($urandom);
            end
            step(s, e);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_stream", strRGB_o, 26'd0);
        chk("rst_goal_l", {25'd0, goal_l}, 26'd0);
        chk("rst_goal_r", {25'd0, goal_r}, 26'd0);
        model_reset();
        @(posedge px_clk);
        @(posedge px_clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [25:0] s;
        reset = 1'b1;
        en = 1'b1;
        strRGB_i = '0;
        rise_l = 0; rise_r = 0;
        #1;
        do_reset();

        // 2: six pixels at x=1 -> one left pulse lasting one frame
        frame(0, 0, 0, 0, 1'b1);
        frame(6, 1, 0, 0, 1'b1);
        frame(0, 0, 0, 0, 1'b1);
        frame(0, 0, 0, 0, 1'b1);
        chk("t2_rise_l", 26'(rise_l), 26'd1);
        chk("t2_rise_r", 26'(rise_r), 26'd0);

        // 3: ball held on the right for 5 frames -> one pulse, re-entry -> second pulse
        rise_l = 0; rise_r = 0;
        for (int f = 0; f < 5; f++) frame(0, 0, 5, 638, 1'b1);
        frame(0, 0, 0, 0, 1'b1);
        frame(0, 0, 0, 0, 1'b1);
        chk("t3_rise_r_held", 26'(rise_r), 26'd1);
        frame(0, 0, 5, 638, 1'b1);
        frame(0, 0, 0, 0, 1'b1);
        frame(0, 0, 0, 0, 1'b1);
        chk("t3_rise_r_reentry", 26'(rise_r), 26'd2);

        // 4: below threshold, then a saturating frame
        rise_l = 0; rise_r = 0;
        frame(3, 2, 0, 0, 1'b1);
        frame(0, 0, 0, 0, 1'b1);
        chk("t4_below_min", 26'(rise_l), 26'd0);
        frame(300, 3, 0, 0, 1'b1);
        frame(0, 0, 0, 0, 1'b1);
        frame(0, 0, 0, 0, 1'b1);
        chk("t4_saturate", 26'(rise_l), 26'd1);

        // 5: both sides in one frame pulse together
        rise_l = 0; rise_r = 0;
        frame(5, 0, 5, 639, 1'b1);
        frame(0, 0, 0, 0, 1'b1);
        frame(0, 0, 0, 0, 1'b1);
        chk("t5_both_l", 26'(rise_l), 26'd1);
        chk("t5_both_r", 26'(rise_r), 26'd1);

        // 1: async reset mid-frame while a left pulse is high
        frame(6, 1, 0, 0, 1'b1);
        s = '0; s[24] = 1'b1;
        step(s, 1'b1);
        chk("t1_pre_reset_goal_l", {25'd0, goal_l}, 26'd1);
        s[24] = 1'b0; s[25] = 1'b1;
        step(s, 1'b1);
        do_reset();

        // 6a: random stream pass-through
        for (int i = 0; i < 200; i++) step(26'($urandom), 1'b1);
        do_reset();

        // 6b: en low during a hit frame -> no pulse
        rise_l = 0; rise_r = 0;
        frame(0, 0, 0, 0, 1'b1);
        frame(6, 1, 6, 637, 1'b0);
        frame(0, 0, 0, 0, 1'b1);
        frame(0, 0, 0, 0, 1'b1);
        chk("t6_en_off_l", 26'(rise_l), 26'd0);
        chk("t6_en_off_r", 26'(rise_r), 26'd0);

        // 6c: en drops while SCORED -> output low next cycle
        frame(6, 1, 0, 0, 1'b1);
        s = '0; s[24] = 1'b1;
        step(s, 1'b1);
        chk("t6_scored_high", {25'd0, goal_l}, 26'd1);
        step(s, 1'b0);
        chk("t6_truncated", {25'd0, goal_l}, 26'd0);
        frame(0, 0, 0, 0, 1'b1);
        frame(0, 0, 0, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
